// File: rtl/rf_pkg.sv
// Shared types and default parameter values for the parametrised register file.
package rf_pkg;

    // Bulk-clear sequencer states.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int W_DEF         = 32;
    localparam int DEPTH_DEF     = 16;
    localparam int PC_OFFSET_DEF = 8;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Bulk-clear sequencer for the register file.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | normal operation; writes and bypass enabled; waits for clr_req
//   CLEAR | zeroes one GP register per cycle at index cnt, 0..DEPTH-2;
//         | GP writes are dropped and bypass is disabled
//
// The write gating lives here because it depends only on the sequencer state.
// Keeping it here leaves the storage in the top as a plain enable-driven array.
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    input  logic          reg_write,
    input  logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          clr_done,
    output logic          wr_drop,
    output logic          wr_en,
    output logic          bypass_en,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] PC_IDX  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_GP = AW'(DEPTH - 2);

    state_e        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          done_q, done_nxt;
    logic          wr_to_gp;

    // Sequencer state, index counter and the registered completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state logic. A clear request in CLEAR is ignored rather than queued.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        clr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                clr_en  = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_GP) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Write gating. PC-addressed writes are neither committed nor reported as dropped.
    always_comb begin
        wr_to_gp  = reg_write && (wr_addr != PC_IDX);
        wr_en     = wr_to_gp && !busy;
        wr_drop   = wr_to_gp && busy;
        bypass_en = reg_write && !busy;
    end

    assign busy     = (state == CLEAR);
    assign clr_done = done_q;
    assign clr_idx  = cnt;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: DEPTH-1 general-purpose registers plus a PC
// register at index DEPTH-1. There are two combinational read ports, with an
// offset on PC reads and write-to-read bypass. There is also a raw debug port
// and a sequential bulk clear.
module reg_file_param
    import rf_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PC_OFFSET = PC_OFFSET_DEF,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          RegWrite,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    input  logic [AW-1:0] A3,
    input  logic [W-1:0]  WD3,
    input  logic [W-1:0]  R15_in,
    input  logic          clr_req,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  RD1,
    output logic [W-1:0]  RD2,
    output logic [W-1:0]  dbg_data,
    output logic [W-1:0]  pc_out,
    output logic          busy,
    output logic          clr_done,
    output logic          wr_drop
);

    localparam logic [AW-1:0] PC_IDX = AW'(DEPTH - 1);
    localparam logic [W-1:0]  PC_OFF = W'(PC_OFFSET);

    logic [W-1:0]  gp_regs [DEPTH-1];
    logic [W-1:0]  pc_reg;
    logic [W-1:0]  pc_plus;
    logic          wr_en;
    logic          bypass_en;
    logic          clr_en;
    logic [AW-1:0] clr_idx;

    rf_clear_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_ctrl (
        .clk       (clk),
        .reset     (reset),
        .clr_req   (clr_req),
        .reg_write (RegWrite),
        .wr_addr   (A3),
        .busy      (busy),
        .clr_done  (clr_done),
        .wr_drop   (wr_drop),
        .wr_en     (wr_en),
        .bypass_en (bypass_en),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx)
    );

    // PC follows R15_in every cycle, including during a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= R15_in;
        end
    end

    // GP storage. The controller never asserts clr_en and wr_en together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                gp_regs[i] <= '0;
            end
        end else if (clr_en) begin
            gp_regs[clr_idx] <= '0;
        end else if (wr_en) begin
            gp_regs[A3] <= WD3;
        end
    end

    assign pc_plus = pc_reg + PC_OFF;
    assign pc_out  = pc_reg;

    // Read port 1: PC reads take priority over the bypass.
    always_comb begin
        RD1 = '0;
        if (A1 == PC_IDX) begin
            RD1 = pc_plus;
        end else if (bypass_en && (A3 == A1)) begin
            RD1 = WD3;
        end else begin
            RD1 = gp_regs[A1];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        RD2 = '0;
        if (A2 == PC_IDX) begin
            RD2 = pc_plus;
        end else if (bypass_en && (A3 == A2)) begin
            RD2 = WD3;
        end else begin
            RD2 = gp_regs[A2];
        end
    end

    // Debug port shows raw storage: no PC offset and no bypass.
    always_comb begin
        dbg_data = '0;
        if (dbg_addr == PC_IDX) begin
            dbg_data = pc_reg;
        end else begin
            dbg_data = gp_regs[dbg_addr];
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: a default 32x16 instance and a 16x8 instance.
module tb_reg_file_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (W=32, DEPTH=16)
    logic        reset, RegWrite, clr_req;
    logic [3:0]  A1, A2, A3, dbg_addr;
    logic [31:0] WD3, R15_in;
    logic [31:0] RD1, RD2, dbg_data, pc_out;
    logic        busy, clr_done, wr_drop;

    // Small instance (W=16, DEPTH=8)
    logic        b_reset, b_RegWrite, b_clr_req;
    logic [2:0]  b_A1, b_A2, b_A3, b_dbg_addr;
    logic [15:0] b_WD3, b_R15_in;
    logic [15:0] b_RD1, b_RD2, b_dbg_data, b_pc_out;
    logic        b_busy, b_clr_done, b_wr_drop;

    reg_file_param u_dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .R15_in(R15_in),
        .clr_req(clr_req), .dbg_addr(dbg_addr),
        .RD1(RD1), .RD2(RD2), .dbg_data(dbg_data), .pc_out(pc_out),
        .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    reg_file_param #(.W(16), .DEPTH(8)) u_dut_b (
        .clk(clk), .reset(b_reset), .RegWrite(b_RegWrite),
        .A1(b_A1), .A2(b_A2), .A3(b_A3), .WD3(b_WD3), .R15_in(b_R15_in),
        .clr_req(b_clr_req), .dbg_addr(b_dbg_addr),
        .RD1(b_RD1), .RD2(b_RD2), .dbg_data(b_dbg_data), .pc_out(b_pc_out),
        .busy(b_busy), .clr_done(b_clr_done), .wr_drop(b_wr_drop)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed %h, no expected value queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_mis++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        expect_val(tag, exp_v);
        check(obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev_r15;
        int          n_busy;

        reset = 1'b1; RegWrite = 1'b0; clr_req = 1'b0;
        A1 = 4'd15; A2 = 4'd0; A3 = 4'd0; dbg_addr = 4'd0;
        WD3 = 32'h0; R15_in = 32'h100;
        b_reset = 1'b1; b_RegWrite = 1'b0; b_clr_req = 1'b0;
        b_A1 = 3'd7; b_A2 = 3'd0; b_A3 = 3'd0; b_dbg_addr = 3'd0;
        b_WD3 = 16'h0; b_R15_in = 16'h0;

        // Reset state
        repeat (2) tick();
        #1;
        chk("rst_pc_out",   pc_out,          32'h0);
        chk("rst_busy",     32'(busy),       32'h0);
        chk("rst_clr_done", 32'(clr_done),   32'h0);
        chk("rst_wr_drop",  32'(wr_drop),    32'h0);
        chk("rst_rd1_pc",   RD1,             32'h8);
        chk("rst_rd2_r0",   RD2,             32'h0);
        reset = 1'b0;
        #1;
        chk("rel_rd1_pc",   RD1,             32'h8);
        tick();
        chk("rel_pc_out",   pc_out,          32'h100);
        chk("rel_rd1_pc2",  RD1,             32'h108);

        // Write with same-cycle bypass on both ports
        RegWrite = 1'b1; A3 = 4'd3; WD3 = 32'hDEADBEEF; A1 = 4'd3; A2 = 4'd3; dbg_addr = 4'd3;
        #1;
        chk("byp_rd1",      RD1,             32'hDEADBEEF);
        chk("byp_rd2",      RD2,             32'hDEADBEEF);
        chk("byp_dbg_raw",  dbg_data,        32'h0);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("wr_hold_rd2",  RD2,             32'hDEADBEEF);
        chk("wr_hold_dbg",  dbg_data,        32'hDEADBEEF);

        // Write aimed at PC is ignored and not reported as dropped
        R15_in = 32'h200; RegWrite = 1'b1; A3 = 4'd15; WD3 = 32'h55; A1 = 4'd15;
        #1;
        chk("pcw_wr_drop",  32'(wr_drop),    32'h0);
        chk("pcw_rd1_nobyp", RD1,            32'h108);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("pcw_pc_out",   pc_out,          32'h200);
        chk("pcw_rd1",      RD1,             32'h208);

        // Load r0..r14 with 0x10+i
        for (int i = 0; i < 15; i++) begin
            RegWrite = 1'b1; A3 = 4'(i); WD3 = 32'h10 + 32'(i);
            tick();
        end
        RegWrite = 1'b0; dbg_addr = 4'd14;
        #1;
        chk("load_r14",     dbg_data,        32'h1E);

        // Bulk clear with a write-while-busy, a bypass attempt and a second clr_req
        A1 = 4'd5; A2 = 4'd0; clr_req = 1'b1;
        prev_r15 = R15_in;
        tick();
        clr_req = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            R15_in   = 32'h300 + 32'(k);
            clr_req  = (k == 7);
            RegWrite = (k == 3) || (k == 4);
            A3       = (k == 3) ? 4'd2 : 4'd0;
            WD3      = (k == 3) ? 32'h77 : 32'h99;
            expect_val($sformatf("clr_busy_k%0d", k),  32'((k <= 15) ? 1 : 0));
            expect_val($sformatf("clr_done_k%0d", k),  32'((k == 16) ? 1 : 0));
            expect_val($sformatf("clr_drop_k%0d", k),  32'((k == 3 || k == 4) ? 1 : 0));
            expect_val($sformatf("clr_r5_k%0d", k),    (k >= 7) ? 32'h0 : 32'h15);
            expect_val($sformatf("clr_r0_k%0d", k),    (k >= 2) ? 32'h0 : 32'h10);
            expect_val($sformatf("clr_pc_k%0d", k),    prev_r15);
            #1;
            check(32'(busy));
            check(32'(clr_done));
            check(32'(wr_drop));
            check(RD1);
            check(RD2);
            check(pc_out);
            prev_r15 = R15_in;
            tick();
        end
        clr_req = 1'b0; RegWrite = 1'b0;
        dbg_addr = 4'd2;  #1; chk("post_clr_r2",  dbg_data, 32'h0);
        dbg_addr = 4'd0;  #1; chk("post_clr_r0",  dbg_data, 32'h0);
        dbg_addr = 4'd14; #1; chk("post_clr_r14", dbg_data, 32'h0);

        // Reset in the 5th busy cycle aborts the clear without clr_done
        tick();
        RegWrite = 1'b1; A3 = 4'd9; WD3 = 32'hAB;
        tick();
        RegWrite = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (4) tick();
        #1;
        chk("midrst_busy_pre", 32'(busy),     32'h1);
        reset = 1'b1;
        #1;
        chk("midrst_busy",     32'(busy),     32'h0);
        chk("midrst_done",     32'(clr_done), 32'h0);
        chk("midrst_pc",       pc_out,        32'h0);
        dbg_addr = 4'd9; A1 = 4'd15;
        #1;
        chk("midrst_r9",       dbg_data,      32'h0);
        chk("midrst_rd1_pc",   RD1,           32'h8);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("midrst_nodone_c%0d", c), 32'(clr_done), 32'h0);
            chk($sformatf("midrst_idle_c%0d", c),   32'(busy),     32'h0);
        end

        // Small instance: PC offset wraps modulo 2^16, DEPTH-2 is writable, clear takes 7 cycles
        b_reset = 1'b0; b_R15_in = 16'hFFFC; b_A1 = 3'd7;
        tick();
        chk("b_pc_out",     32'(b_pc_out),   32'h0000FFFC);
        chk("b_rd1_wrap",   32'(b_RD1),      32'h00000004);
        b_RegWrite = 1'b1; b_A3 = 3'd6; b_WD3 = 16'hABCD; b_A2 = 3'd6; b_dbg_addr = 3'd6;
        #1;
        chk("b_byp_rd2",    32'(b_RD2),      32'h0000ABCD);
        tick();
        b_RegWrite = 1'b1; b_A3 = 3'd7; b_WD3 = 16'h1111;
        #1;
        chk("b_r6",         32'(b_dbg_data), 32'h0000ABCD);
        chk("b_pcw_drop",   32'(b_wr_drop),  32'h0);
        tick();
        b_RegWrite = 1'b0;
        chk("b_pcw_ignored", 32'(b_pc_out),  32'h0000FFFC);
        b_clr_req = 1'b1;
        tick();
        b_clr_req = 1'b0;
        n_busy = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!b_busy) break;
            n_busy++;
            tick();
        end
        chk("b_busy_cycles", 32'(n_busy),     32'd7);
        chk("b_clr_done",    32'(b_clr_done), 32'h1);
        chk("b_r6_cleared",  32'(b_dbg_data), 32'h0);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL scoreboard_leftover: observed %0d unchecked entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
